cmn_tree_plru_seq: RTL
======================

Name: cmn_tree_plru_seq

Overview:
- Registered, multi-set tree-PLRU replacement engine for set-associative structures such as caches, TLBs and predictor tables.
- Holds one (WAYS-1)-bit PLRU tree per set.
- Applies hit/touch updates, returns a registered victim way per allocation request, honours invalid-way priority and per-way lock masks, and supports a sequenced flush.
- Sits beside the tag array; the allocation pipeline consumes the victim one cycle after request.

Parameters:
- WAYS, 8, associativity; power of two, >=2.
- SETS, 16, number of independent trees; >=1.
- WAY_W, $clog2(WAYS), encoded way width.
- SET_W, (SETS>1)?$clog2(SETS):1, set index width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- touch_vld  input  1  hit update request.
- touch_set  input  SET_W  set of touch.
- touch_way  input  WAYS  one-hot way touched; zero ignored.
- vic_req_vld  input  1  victim request (implies allocation).
- vic_req_set  input  SET_W  set of request.
- vic_valid  input  WAYS  per-way valid bits of that set.
- vic_lock  input  WAYS  per-way lock; a locked way is never chosen.
- vic_rsp_vld  output  1  victim response valid (1 cycle after req).
- vic_rsp_way  output  WAYS  one-hot victim; 0 when none.
- vic_rsp_idx  output  WAY_W  encoded victim.
- vic_rsp_none  output  1  all ways locked, no victim.
- flush_req  input  1  pulse; start clearing all trees.
- busy  output  1  flush in progress; requests not accepted.

Behaviour:
- Tree layout:
  - Heap order: node 2^i+j-1 is level i, offset j; node 0 is the root.
  - Node=1 means the left half was more recent, so the tree points right.
  - Node=0 points left.
- Touch update, for each node on the path of way w:
  - Node := 1 if w is in the left subtree.
  - Node := 0 if w is in the right subtree.
  - Off-path nodes are unchanged.
  - Written at the next edge; visible to a request in the following cycle.
- Victim selection, combinational on the current (pre-update) tree, registered at the edge:
  1. Lowest-index way with vic_valid=0 and vic_lock=0, if any exists.
  2. Otherwise walk from the root following the node bits. At any node whose preferred subtree is entirely locked, take the other subtree.
  3. If every way is locked: vic_rsp_none=1, vic_rsp_way=0, vic_rsp_idx=0, and no tree update.
- Allocation update: the chosen victim is applied to its set as a touch at the same edge as the response.
- Simultaneous touch and victim:
  - Different sets: both updates applied.
  - Same set: the touch is applied first, then the victim update; the victim path wins on shared nodes. Victim selection ignores the same-cycle touch.
- Response timing:
  - vic_rsp_vld = registered vic_req_vld & ~busy.
  - Response fields are held until the next response and are 0 after reset.
- FSM IDLE/FLUSH:
  - A flush_req pulse in IDLE moves to FLUSH, with flush counter = 0 and busy=1.
  - FLUSH clears one set per cycle, for SETS cycles, then returns to IDLE. busy deasserts in the cycle after the last set is cleared.
  - In FLUSH, touch_vld and vic_req_vld are ignored (no response, no update).
  - flush_req while already in FLUSH is ignored.
- Reset:
  - All trees cleared to 0; FSM to IDLE; busy=0; vic_rsp_vld=0; all response fields 0.
  - Reset asserted mid-flush aborts the flush and clears everything the same cycle.
  - A request in the reset cycle gets no response.
- Width rules:
  - Trees stored as SETS x (WAYS-1) flops.
  - WAYS=2 gives a single-node tree.
  - touch_way is not checked for one-hot; behaviour with multiple bits set is undefined (assertion in sim).
- Set index >= SETS is undefined (assertion).

Test Plan:
- WAYS=4, reset, then vic_req set 2 with vic_valid=4'b1111, lock=0 -> next cycle vic_rsp_way=4'b0001, idx=0; tree[2] becomes 3'b011.
- Reset; touch set 2 way0; next cycle vic_req set 2, all valid -> vic_rsp_way=4'b0100 (root=1 goes right, node2=0 goes left).
- vic_req with vic_valid=4'b1011, lock=0 -> victim way2 (invalid priority) regardless of tree; tree[set] path updated for way2.
- Tree pointing at way0, lock=4'b0011, all valid -> victim way2. Then lock=4'b1111 -> vic_rsp_none=1, way=0, tree unchanged.
- Same-cycle touch way3 and vic_req on set 5 from reset tree -> victim way0 (pre-update). Final tree[5]: root=1, node1=1, node2=0 (victim wins root).
- SETS=16: flush_req -> busy high 16 cycles and all trees read 0 afterwards. A vic_req during busy gets no response. Reset at flush cycle 7 -> busy=0 next cycle, all trees 0.

Source files
------------

// File: rtl/cmn_tree_plru_seq.sv
// Multi-set tree-PLRU replacement engine: touch updates, registered victim
// selection with invalid-way priority and per-way locks, and a sequenced flush.
module cmn_tree_plru_seq #(
  parameter int unsigned WAYS  = 8,
  parameter int unsigned SETS  = 16,
  parameter int unsigned WAY_W = $clog2(WAYS),
  parameter int unsigned SET_W = (SETS > 1) ? $clog2(SETS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             touch_vld,
  input  logic [SET_W-1:0] touch_set,
  input  logic [WAYS-1:0]  touch_way,
  input  logic             vic_req_vld,
  input  logic [SET_W-1:0] vic_req_set,
  input  logic [WAYS-1:0]  vic_valid,
  input  logic [WAYS-1:0]  vic_lock,
  output logic             vic_rsp_vld,
  output logic [WAYS-1:0]  vic_rsp_way,
  output logic [WAY_W-1:0] vic_rsp_idx,
  output logic             vic_rsp_none,
  input  logic             flush_req,
  output logic             busy
);

  localparam int unsigned NODES  = WAYS - 1;
  localparam int unsigned NODE_W = (NODES > 1) ? $clog2(NODES) : 1;

  typedef logic [NODES-1:0] tree_t;
  typedef enum logic {S_IDLE = 1'b0, S_FLUSH = 1'b1} state_e;

  // Heap-ordered tree: a node is set when its left half was used last,
  // so the replacement pointer then leans right.
  function automatic tree_t tree_touch(input tree_t t, input logic [WAY_W-1:0] w);
    tree_t            r;
    logic [WAY_W-1:0] ws;
    int unsigned      node;
    logic             go_right;
    r    = t;
    ws   = w;
    node = 0;
    for (int unsigned lvl = 0; lvl < WAY_W; lvl++) begin
      go_right         = ws[WAY_W-1];
      r[NODE_W'(node)] = ~go_right;
      node             = 2 * node + 1 + 32'(go_right);
      ws               = ws << 1;
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [SET_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             busy_q, busy_d;
  tree_t            tree_q [SETS];
  tree_t            tree_d [SETS];

  logic             rsp_vld_q, rsp_vld_d;
  logic [WAYS-1:0]  rsp_way_q, rsp_way_d;
  logic [WAY_W-1:0] rsp_idx_q, rsp_idx_d;
  logic             rsp_none_q, rsp_none_d;

  tree_t            vic_tree;
  logic [WAYS-1:0]  free_ways;
  logic             inv_hit;
  logic             all_locked;
  logic [WAY_W-1:0] inv_idx;
  logic [WAY_W-1:0] walk_idx;
  logic [WAY_W-1:0] vic_idx_c;
  logic [WAYS-1:0]  vic_way_c;
  int               walk_pos;
  int               walk_node;
  logic             left_lk;
  logic             right_lk;
  logic             walk_right;

  logic [WAY_W-1:0] touch_idx;
  logic             touch_en;
  logic             alloc_en;
  tree_t            touched_tree;
  tree_t            alloc_base;

  // Victim choice on the pre-update tree: free invalid way first, else a
  // lock-aware walk that steers away from fully locked subtrees.
  always_comb begin
    free_ways  = ~vic_valid & ~vic_lock;
    inv_hit    = |free_ways;
    all_locked = &vic_lock;
    inv_idx    = '0;
    for (int k = int'(WAYS) - 1; k >= 0; k--) begin
      if (free_ways[k]) inv_idx = WAY_W'(k);
    end

    vic_tree   = tree_q[vic_req_set];
    walk_pos   = 0;
    walk_node  = 0;
    left_lk    = 1'b1;
    right_lk   = 1'b1;
    walk_right = 1'b0;
    for (int lvl = 0; lvl < int'(WAY_W); lvl++) begin
      left_lk  = 1'b1;
      right_lk = 1'b1;
      for (int k = 0; k < int'(WAYS); k++) begin
        if ((k >> (int'(WAY_W) - 1 - lvl)) == 2 * walk_pos)     left_lk  = left_lk  & vic_lock[k];
        if ((k >> (int'(WAY_W) - 1 - lvl)) == 2 * walk_pos + 1) right_lk = right_lk & vic_lock[k];
      end
      walk_right = vic_tree[NODE_W'(walk_node)];
      if (walk_right ? right_lk : left_lk) walk_right = ~walk_right;
      walk_pos  = 2 * walk_pos + int'(walk_right);
      walk_node = 2 * walk_node + 1 + int'(walk_right);
    end
    walk_idx = WAY_W'(walk_pos);

    vic_idx_c = inv_hit ? inv_idx : walk_idx;
    vic_way_c = all_locked ? '0 : (WAYS'(1) << vic_idx_c);
  end

  // Tree next-state: flush clears one set per cycle; otherwise touch first,
  // then the allocation so the victim path wins shared nodes.
  always_comb begin
    touch_idx = '0;
    for (int k = 0; k < int'(WAYS); k++) begin
      if (touch_way[k]) touch_idx = touch_idx | WAY_W'(k);
    end
    touch_en     = touch_vld & (|touch_way) & ~busy_q;
    alloc_en     = vic_req_vld & ~busy_q & ~all_locked;
    touched_tree = tree_touch(tree_q[touch_set], touch_idx);
    alloc_base   = (touch_en && (touch_set == vic_req_set)) ? touched_tree
                                                            : tree_q[vic_req_set];
    tree_d = tree_q;
    if (state_q == S_FLUSH) begin
      tree_d[flush_cnt_q] = '0;
    end else begin
      if (touch_en) tree_d[touch_set]   = touched_tree;
      if (alloc_en) tree_d[vic_req_set] = tree_touch(alloc_base, vic_idx_c);
    end
  end

  // Flush sequencing and response capture.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (flush_req) begin
          state_d     = S_FLUSH;
          flush_cnt_d = '0;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == SET_W'(SETS - 1)) state_d = S_IDLE;
        else                                 flush_cnt_d = flush_cnt_q + SET_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_FLUSH);

    rsp_vld_d  = vic_req_vld & ~busy_q;
    rsp_way_d  = rsp_way_q;
    rsp_idx_d  = rsp_idx_q;
    rsp_none_d = rsp_none_q;
    if (rsp_vld_d) begin
      rsp_way_d  = vic_way_c;
      rsp_idx_d  = all_locked ? '0 : vic_idx_c;
      rsp_none_d = all_locked;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      flush_cnt_q <= '0;
      busy_q      <= 1'b0;
      tree_q      <= '{default: '0};
      rsp_vld_q   <= 1'b0;
      rsp_way_q   <= '0;
      rsp_idx_q   <= '0;
      rsp_none_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      busy_q      <= busy_d;
      tree_q      <= tree_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_way_q   <= rsp_way_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_none_q  <= rsp_none_d;
    end
  end

  assign vic_rsp_vld  = rsp_vld_q;
  assign vic_rsp_way  = rsp_way_q;
  assign vic_rsp_idx  = rsp_idx_q;
  assign vic_rsp_none = rsp_none_q;
  assign busy         = busy_q;

  // Simulation checks on caller-guaranteed input properties.
  a_touch_onehot: assert property (@(posedge clk) disable iff (rst)
    touch_vld |-> $onehot0(touch_way));
  a_touch_set: assert property (@(posedge clk) disable iff (rst)
    touch_vld |-> (32'(touch_set) < SETS));
  a_vic_set: assert property (@(posedge clk) disable iff (rst)
    vic_req_vld |-> (32'(vic_req_set) < SETS));

endmodule
